// File: rtl/alu_result_fifo_if.sv
// rtl/alu_result_fifo_if.sv - upstream/downstream handshake bundle for the ALU result stage
interface alu_result_fifo_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carryout;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_negative;
  logic             out_carryout;
  logic             out_overflow;

  modport master (
    output in_valid, in_result, in_carryout, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_negative,
           out_carryout, out_overflow
  );

  modport slave (
    input  in_valid, in_result, in_carryout, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_negative,
           out_carryout, out_overflow
  );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - buffered ALU result stage with capture-time flags and sticky overflow
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  alu_result_fifo_if.slave           bus,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clear_sticky,
  output logic                       sticky_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 4;

  // entry layout: {result, zero, negative, carryout, overflow}
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          enq;
  logic          deq;
  logic [EW-1:0] head;
  logic [EW-1:0] entry_in;

  assign bus.in_ready  = (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign enq = bus.in_valid && bus.in_ready;
  assign deq = bus.out_valid && bus.out_ready;

  assign entry_in = {bus.in_result, ~|bus.in_result, bus.in_result[WIDTH-1],
                     bus.in_carryout, bus.in_overflow};

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (enq && !deq) begin
        count <= count + CW'(1);
      end else if (deq && !enq) begin
        count <= count - CW'(1);
      end
    end
  end

  // a new overflow in the same cycle as a clear takes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_overflow <= 1'b0;
    end else if (enq && bus.in_overflow) begin
      sticky_overflow <= 1'b1;
    end else if (clear_sticky) begin
      sticky_overflow <= 1'b0;
    end
  end

  assign head = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_result   = head[EW-1:4];
  assign bus.out_zero     = head[3];
  assign bus.out_negative = head[2];
  assign bus.out_carryout = head[1];
  assign bus.out_overflow = head[0];
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - directed self-checking bench for alu_result_fifo
module tb_alu_result_fifo;
  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       clear_sticky;
  logic       sticky_overflow;
  int         n_checks;
  int         n_errors;
  logic [31:0] exp_q [4];

  alu_result_fifo_if #(.WIDTH(32)) bus ();

  alu_result_fifo #(.DEPTH(4), .WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave),
    .count           (count),
    .clear_sticky    (clear_sticky),
    .sticky_overflow (sticky_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic ovf);
    bus.in_valid    = 1'b1;
    bus.in_result   = data;
    bus.in_overflow = ovf;
    step();
    bus.in_valid    = 1'b0;
    bus.in_overflow = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] expv);
    chk(tag, bus.out_result, expv);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    reset            = 1'b1;
    clear_sticky     = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_result    = '0;
    bus.in_carryout  = 1'b0;
    bus.in_overflow  = 1'b0;
    bus.out_ready    = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_sticky", 32'(sticky_overflow), 32'd0);

    // single zero-valued entry
    bus.in_carryout = 1'b1;
    push(32'h0, 1'b0);
    bus.in_carryout = 1'b0;
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_zero", 32'(bus.out_zero), 32'd1);
    chk("single_neg", 32'(bus.out_negative), 32'd0);
    chk("single_carry", 32'(bus.out_carryout), 32'd1);
    chk("single_count", 32'(count), 32'd1);
    pop_check("single_result", 32'h0);
    chk("single_empty", 32'(bus.out_valid), 32'd0);
    chk("single_count0", 32'(count), 32'd0);
    chk("single_out_gated", 32'(bus.out_carryout), 32'd0);

    // fill and backpressure
    exp_q[0] = 32'h1; exp_q[1] = 32'h2; exp_q[2] = 32'h3; exp_q[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) push(exp_q[i], 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    push(32'h5, 1'b0);
    chk("full_reject_count", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) pop_check("drain", exp_q[i]);
    chk("drain_neg", 32'(bus.out_negative), 32'd1);
    chk("drain_zero", 32'(bus.out_zero), 32'd0);
    pop_check("drain_last", 32'h8000_0000);
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // full with simultaneous pop: no same-cycle refill
    exp_q[0] = 32'hA; exp_q[1] = 32'hB; exp_q[2] = 32'hC; exp_q[3] = 32'hD;
    for (int i = 0; i < 4; i++) push(exp_q[i], 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_result = 32'h9;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fullpop_head", bus.out_result, 32'hB);
    step();
    bus.in_valid = 1'b0;
    chk("fullpop_refill", 32'(count), 32'd4);
    pop_check("fp_drain0", 32'hB);
    pop_check("fp_drain1", 32'hC);
    pop_check("fp_drain2", 32'hD);
    pop_check("fp_drain3", 32'h9);
    chk("fp_empty", 32'(count), 32'd0);

    // streaming at one entry per cycle
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_result = 32'(i);
      step();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_data", bus.out_result, 32'(i));
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    chk("stream_empty", 32'(count), 32'd0);

    // sticky overflow
    push(32'h7FFF_FFFF, 1'b1);
    chk("sticky_set", 32'(sticky_overflow), 32'd1);
    chk("head_ovf", 32'(bus.out_overflow), 32'd1);
    clear_sticky = 1'b1;
    push(32'h1, 1'b1);
    clear_sticky = 1'b0;
    chk("sticky_set_wins", 32'(sticky_overflow), 32'd1);
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    chk("sticky_cleared", 32'(sticky_overflow), 32'd0);
    push(32'h2, 1'b0);
    push(32'h3, 1'b0);
    chk("sticky_full", 32'(count), 32'd4);
    push(32'h4, 1'b1);
    chk("sticky_full_ignored", 32'(sticky_overflow), 32'd0);
    chk("sticky_full_count", 32'(count), 32'd4);

    // reset mid-stream
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("mid_count3", 32'(count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", bus.out_result, 32'd0);
    chk("mid_rst_sticky", 32'(sticky_overflow), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    push(32'h1234, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    pop_check("post_rst_data", 32'h1234);
    chk("post_rst_empty", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
